// File: rtl/alu_pkg.sv
// Shared encodings and constants for the ALU request sequencer.
package alu_pkg;

    localparam int unsigned IN_VAL_W = 2;
    localparam int unsigned FLAG_W   = 6;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned LAT_W    = 2;

    // Arithmetic-mode commands
    localparam int unsigned CMD_ADD     = 0;
    localparam int unsigned CMD_SUB     = 1;
    localparam int unsigned CMD_ADD_CIN = 2;
    localparam int unsigned CMD_SUB_CIN = 3;
    localparam int unsigned CMD_INC_A   = 4;
    localparam int unsigned CMD_DEC_A   = 5;
    localparam int unsigned CMD_INC_B   = 6;
    localparam int unsigned CMD_DEC_B   = 7;
    localparam int unsigned CMD_CMP     = 8;
    localparam int unsigned CMD_MUL_INC = 9;
    localparam int unsigned CMD_MUL_SHL = 10;

    // Logic-mode commands
    localparam int unsigned CMD_AND    = 0;
    localparam int unsigned CMD_NAND   = 1;
    localparam int unsigned CMD_OR     = 2;
    localparam int unsigned CMD_NOR    = 3;
    localparam int unsigned CMD_XOR    = 4;
    localparam int unsigned CMD_XNOR   = 5;
    localparam int unsigned CMD_NOT_A  = 6;
    localparam int unsigned CMD_NOT_B  = 7;
    localparam int unsigned CMD_SHR1_A = 8;
    localparam int unsigned CMD_SHL1_A = 9;
    localparam int unsigned CMD_SHR1_B = 10;
    localparam int unsigned CMD_SHL1_B = 11;
    localparam int unsigned CMD_ROL    = 12;
    localparam int unsigned CMD_ROR    = 13;

    typedef enum logic [IN_VAL_W-1:0] {
        IN_NONE = 2'b00,
        IN_A    = 2'b01,
        IN_B    = 2'b10,
        IN_AB   = 2'b11
    } in_val_e;

    localparam int unsigned LAT_BASE = 2;
    localparam int unsigned LAT_MUL  = 3;

    localparam int unsigned FLAG_ERR  = 5;
    localparam int unsigned FLAG_OF   = 4;
    localparam int unsigned FLAG_COUT = 3;
    localparam int unsigned FLAG_G    = 2;
    localparam int unsigned FLAG_L    = 1;
    localparam int unsigned FLAG_E    = 0;

endpackage

// File: rtl/alu_sequencer_if.sv
// Request, ALU-drive, ALU-result and response signals of the sequencer.
interface alu_sequencer_if
    import alu_pkg::*;
#(
    parameter int unsigned op_len  = 8,
    parameter int unsigned cmd_len = 4
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic [op_len-1:0]     req_opa;
    logic [op_len-1:0]     req_opb;
    logic [cmd_len-1:0]    req_cmd;
    logic                  req_mode;
    logic                  req_cin;
    logic [IN_VAL_W-1:0]   req_in_val;

    logic [op_len-1:0]     alu_opa;
    logic [op_len-1:0]     alu_opb;
    logic [cmd_len-1:0]    alu_cmd;
    logic                  alu_mode;
    logic                  alu_cin;
    logic                  alu_ce;
    logic [IN_VAL_W-1:0]   alu_in_val;

    logic [2*op_len-1:0]   alu_res;
    logic                  alu_err, alu_of, alu_cout, alu_g, alu_l, alu_e;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [2*op_len-1:0]   rsp_res;
    logic [FLAG_W-1:0]     rsp_flags;
    logic                  rsp_illegal;
    logic [cmd_len-1:0]    rsp_cmd;

    logic [CNT_W-1:0]      op_count;
    logic [CNT_W-1:0]      illegal_count;

    modport master (
        output req_valid, req_opa, req_opb, req_cmd, req_mode, req_cin, req_in_val,
        output alu_res, alu_err, alu_of, alu_cout, alu_g, alu_l, alu_e, rsp_ready,
        input  req_ready, alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin, alu_ce, alu_in_val,
        input  rsp_valid, rsp_res, rsp_flags, rsp_illegal, rsp_cmd, op_count, illegal_count
    );

    modport slave (
        input  req_valid, req_opa, req_opb, req_cmd, req_mode, req_cin, req_in_val,
        input  alu_res, alu_err, alu_of, alu_cout, alu_g, alu_l, alu_e, rsp_ready,
        output req_ready, alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin, alu_ce, alu_in_val,
        output rsp_valid, rsp_res, rsp_flags, rsp_illegal, rsp_cmd, op_count, illegal_count
    );
endinterface

// File: rtl/alu_cmd_legal.sv
// Combinational legality check of a (mode, in_val, cmd) request triple.
module alu_cmd_legal
    import alu_pkg::*;
#(
    parameter int unsigned cmd_len = 4
) (
    input  logic                mode,
    input  logic [IN_VAL_W-1:0] in_val,
    input  logic [cmd_len-1:0]  cmd,
    output logic                legal
);
    logic [31:0] cmd_w;
    logic [15:0] mask;

    assign cmd_w = 32'(cmd);

    // One bit per command value that is legal for this mode/operand combination
    always_comb begin
        mask = 16'h0000;
        case (in_val)
            IN_A:    mask = mode ? 16'h0030 : 16'h0340;
            IN_B:    mask = mode ? 16'h00C0 : 16'h0C80;
            IN_AB:   mask = mode ? 16'h1F0F : 16'h303F;
            default: mask = 16'h0000;
        endcase
    end

    assign legal = (cmd_w < 32'd16) && mask[cmd_w[3:0]];
endmodule

// File: rtl/alu_sequencer.sv
// Accepts one ALU request at a time, drives the ALU for its latency and
// returns the captured result through a held response handshake.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned op_len  = 8,
    parameter int unsigned cmd_len = 4
) (
    input logic           clk,
    input logic           rst,
    alu_sequencer_if.slave bus
);
    localparam int unsigned RES_W = 2 * op_len;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic                alu_ce_q, alu_ce_d;
    logic [op_len-1:0]   alu_opa_q, alu_opa_d, alu_opb_q, alu_opb_d;
    logic [cmd_len-1:0]  alu_cmd_q, alu_cmd_d;
    logic                alu_mode_q, alu_mode_d, alu_cin_q, alu_cin_d;
    logic [IN_VAL_W-1:0] alu_in_val_q, alu_in_val_d;
    logic                rsp_valid_q, rsp_valid_d, rsp_illegal_q, rsp_illegal_d;
    logic [RES_W-1:0]    rsp_res_q, rsp_res_d;
    logic [FLAG_W-1:0]   rsp_flags_q, rsp_flags_d;
    logic [cmd_len-1:0]  rsp_cmd_q, rsp_cmd_d;
    logic [CNT_W-1:0]    op_cnt_q, op_cnt_d, ill_cnt_q, ill_cnt_d;
    logic                legal, is_mul;

    alu_cmd_legal #(.cmd_len(cmd_len)) u_legal (
        .mode   (bus.req_mode),
        .in_val (bus.req_in_val),
        .cmd    (bus.req_cmd),
        .legal  (legal)
    );

    assign is_mul = bus.req_mode &&
                    ((32'(bus.req_cmd) == CMD_MUL_INC) || (32'(bus.req_cmd) == CMD_MUL_SHL));

    // Next-state and next-output logic; lat_q counts down to the capture edge
    always_comb begin
        state_d      = state_q;
        lat_d        = lat_q;
        alu_ce_d     = alu_ce_q;
        alu_opa_d    = alu_opa_q;
        alu_opb_d    = alu_opb_q;
        alu_cmd_d    = alu_cmd_q;
        alu_mode_d   = alu_mode_q;
        alu_cin_d    = alu_cin_q;
        alu_in_val_d = alu_in_val_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_illegal_d= rsp_illegal_q;
        rsp_res_d    = rsp_res_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_cmd_d    = rsp_cmd_q;
        op_cnt_d     = op_cnt_q;
        ill_cnt_d    = ill_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    rsp_cmd_d = bus.req_cmd;
                    if (legal) begin
                        alu_opa_d    = bus.req_opa;
                        alu_opb_d    = bus.req_opb;
                        alu_cmd_d    = bus.req_cmd;
                        alu_mode_d   = bus.req_mode;
                        alu_cin_d    = bus.req_cin;
                        alu_in_val_d = bus.req_in_val;
                        alu_ce_d     = 1'b1;
                        lat_d        = is_mul ? LAT_W'(LAT_MUL) : LAT_W'(LAT_BASE);
                        state_d      = S_EXEC;
                    end else begin
                        rsp_valid_d   = 1'b1;
                        rsp_illegal_d = 1'b1;
                        rsp_res_d     = '0;
                        rsp_flags_d   = '0;
                        ill_cnt_d     = ill_cnt_q + CNT_W'(1);
                        state_d       = S_RESP;
                    end
                end
            end
            S_EXEC: begin
                if (lat_q == '0) begin
                    rsp_res_d              = bus.alu_res;
                    rsp_flags_d[FLAG_ERR]  = bus.alu_err;
                    rsp_flags_d[FLAG_OF]   = bus.alu_of;
                    rsp_flags_d[FLAG_COUT] = bus.alu_cout;
                    rsp_flags_d[FLAG_G]    = bus.alu_g;
                    rsp_flags_d[FLAG_L]    = bus.alu_l;
                    rsp_flags_d[FLAG_E]    = bus.alu_e;
                    rsp_illegal_d          = 1'b0;
                    rsp_valid_d            = 1'b1;
                    alu_ce_d               = 1'b0;
                    alu_opa_d              = '0;
                    alu_opb_d              = '0;
                    alu_cmd_d              = '0;
                    alu_mode_d             = 1'b0;
                    alu_cin_d              = 1'b0;
                    alu_in_val_d           = '0;
                    state_d                = S_RESP;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_cnt_d    = op_cnt_q + CNT_W'(1);
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            lat_q         <= '0;
            alu_ce_q      <= 1'b0;
            alu_opa_q     <= '0;
            alu_opb_q     <= '0;
            alu_cmd_q     <= '0;
            alu_mode_q    <= 1'b0;
            alu_cin_q     <= 1'b0;
            alu_in_val_q  <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_illegal_q <= 1'b0;
            rsp_res_q     <= '0;
            rsp_flags_q   <= '0;
            rsp_cmd_q     <= '0;
            op_cnt_q      <= '0;
            ill_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            lat_q         <= lat_d;
            alu_ce_q      <= alu_ce_d;
            alu_opa_q     <= alu_opa_d;
            alu_opb_q     <= alu_opb_d;
            alu_cmd_q     <= alu_cmd_d;
            alu_mode_q    <= alu_mode_d;
            alu_cin_q     <= alu_cin_d;
            alu_in_val_q  <= alu_in_val_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_illegal_q <= rsp_illegal_d;
            rsp_res_q     <= rsp_res_d;
            rsp_flags_q   <= rsp_flags_d;
            rsp_cmd_q     <= rsp_cmd_d;
            op_cnt_q      <= op_cnt_d;
            ill_cnt_q     <= ill_cnt_d;
        end
    end

    // Ready follows the state directly so it is low throughout reset and high right after
    assign bus.req_ready     = (state_q == S_IDLE) && !rst;
    assign bus.alu_ce        = alu_ce_q;
    assign bus.alu_opa       = alu_opa_q;
    assign bus.alu_opb       = alu_opb_q;
    assign bus.alu_cmd       = alu_cmd_q;
    assign bus.alu_mode      = alu_mode_q;
    assign bus.alu_cin       = alu_cin_q;
    assign bus.alu_in_val    = alu_in_val_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_illegal   = rsp_illegal_q;
    assign bus.rsp_res       = rsp_res_q;
    assign bus.rsp_flags     = rsp_flags_q;
    assign bus.rsp_cmd       = rsp_cmd_q;
    assign bus.op_count      = op_cnt_q;
    assign bus.illegal_count = ill_cnt_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed and random requests against a behavioural ALU and a rule-level reference model.
module tb_alu_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   exp_ops = 0;
    int   exp_ill = 0;
    int   ce_age  = 0;

    alu_sequencer_if #(.op_len(8), .cmd_len(4)) bus ();

    alu_sequencer #(.op_len(8), .cmd_len(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Test ALU: {err,of,cout,g,l,e, res[15:0]} as a plain function of the operands
    function automatic logic [21:0] alu_fn(input logic m, input logic [3:0] c,
                                           input logic [7:0] a, input logic [7:0] b,
                                           input logic ci);
        logic [15:0] aa, bb, r;
        aa = {8'h00, a};
        bb = {8'h00, b};
        if (m) begin
            case (c)
                4'd0:    r = aa + bb;
                4'd1:    r = aa - bb;
                4'd2:    r = aa + bb + 16'(ci);
                4'd3:    r = aa - bb - 16'(ci);
                4'd4:    r = aa + 16'd1;
                4'd5:    r = aa - 16'd1;
                4'd6:    r = bb + 16'd1;
                4'd7:    r = bb - 16'd1;
                4'd8:    r = 16'd0;
                4'd9:    r = (aa + 16'd1) * (bb + 16'd1);
                4'd10:   r = (aa << 1) * bb;
                default: r = aa ^ bb;
            endcase
        end else begin
            r = {8'h00, (c[0] ? (a & b) : (a | b))} ^ {12'h000, c};
        end
        return {r[0] ^ r[1], r[15], r[8], a > b, a < b, a == b, r};
    endfunction

    function automatic bit ref_legal(input logic m, input logic [1:0] iv, input logic [3:0] c);
        if (iv == 2'b00) return 1'b0;
        if (m) begin
            if (iv == 2'b01) return c inside {4, 5};
            if (iv == 2'b10) return c inside {6, 7};
            return c inside {[0:3], [8:12]};
        end
        if (iv == 2'b01) return c inside {6, 8, 9};
        if (iv == 2'b10) return c inside {7, 10, 11};
        return c inside {[0:5], 12, 13};
    endfunction

    function automatic int ref_lat(input logic m, input logic [3:0] c);
        return (m && (c == 4'd9 || c == 4'd10)) ? 3 : 2;
    endfunction

    // Cycles alu_ce has been high; the ALU presents garbage until its latency has elapsed
    always @(posedge clk or posedge rst) begin
        if (rst || !bus.alu_ce) ce_age <= 0;
        else                    ce_age <= ce_age + 1;
    end

    always_comb begin
        logic [21:0] v;
        v = alu_fn(bus.alu_mode, bus.alu_cmd, bus.alu_opa, bus.alu_opb, bus.alu_cin);
        if (!(bus.alu_ce && ce_age >= ref_lat(bus.alu_mode, bus.alu_cmd))) v = ~v;
        bus.alu_res = v[15:0];
        {bus.alu_err, bus.alu_of, bus.alu_cout, bus.alu_g, bus.alu_l, bus.alu_e} = v[21:16];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a clock edge with the sequencer idle
    task automatic send(input logic m, input logic [3:0] c, input logic [1:0] iv,
                        input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input int hold);
        bit          lg;
        int          n, ce_n, exp_n;
        bit          alu_bad;
        logic [21:0] v;
        logic [63:0] snap;
        lg    = ref_legal(m, iv, c);
        v     = alu_fn(m, c, a, b, ci);
        // response seen after E0+L+1 for a legal request, straight after E0 otherwise
        exp_n = lg ? ref_lat(m, c) + 1 : 0;
        chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1; bus.req_mode = m; bus.req_cmd = c; bus.req_in_val = iv;
        bus.req_opa = a; bus.req_opb = b; bus.req_cin = ci;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_opa = 8'($urandom); bus.req_opb = 8'($urandom);
        n = 0; ce_n = 0; alu_bad = 1'b0;
        while (bus.rsp_valid !== 1'b1 && n < 10) begin
            if (bus.req_ready !== 1'b0) alu_bad = 1'b1;
            if (bus.alu_ce === 1'b1) begin
                ce_n++;
                if ({bus.alu_opa, bus.alu_opb, bus.alu_cmd, bus.alu_mode, bus.alu_cin,
                     bus.alu_in_val} !== {a, b, c, m, ci, iv}) alu_bad = 1'b1;
            end
            @(posedge clk); #1;
            n++;
        end
        chk("rsp_latency", 64'(n), 64'(exp_n));
        chk("alu_ce_cycles", 64'(ce_n), 64'(lg ? exp_n : 0));
        chk("exec_drive_ok", 64'(alu_bad), 64'd0);
        chk("alu_idle_zero", 64'({bus.alu_ce, bus.alu_opa, bus.alu_opb, bus.alu_cmd,
                                  bus.alu_mode, bus.alu_cin, bus.alu_in_val}), 64'd0);
        if (!lg) exp_ill++;
        chk("rsp_res", 64'(bus.rsp_res), lg ? 64'(v[15:0]) : 64'd0);
        chk("rsp_flags", 64'(bus.rsp_flags), lg ? 64'(v[21:16]) : 64'd0);
        chk("rsp_illegal", 64'(bus.rsp_illegal), 64'(!lg));
        chk("rsp_cmd", 64'(bus.rsp_cmd), 64'(c));
        chk("illegal_count", 64'(bus.illegal_count), 64'(16'(exp_ill)));
        snap = 64'({bus.rsp_valid, bus.rsp_res, bus.rsp_flags, bus.rsp_illegal, bus.rsp_cmd});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("rsp_hold", 64'({bus.rsp_valid, bus.rsp_res, bus.rsp_flags, bus.rsp_illegal,
                                 bus.rsp_cmd, bus.req_ready}), {snap[62:0], 1'b0});
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        exp_ops++;
        chk("rsp_valid_clear", 64'(bus.rsp_valid), 64'd0);
        chk("op_count", 64'(bus.op_count), 64'(16'(exp_ops)));
        chk("req_ready_back", 64'(bus.req_ready), 64'd1);
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_opa = '0; bus.req_opb = '0; bus.req_cmd = '0;
        bus.req_mode = 1'b0; bus.req_cin = 1'b0; bus.req_in_val = '0; bus.rsp_ready = 1'b0;

        // Reset state
        #1;
        chk("reset_ready", 64'(bus.req_ready), 64'd0);
        chk("reset_alu", 64'({bus.alu_ce, bus.alu_opa, bus.alu_opb, bus.alu_cmd}), 64'd0);
        chk("reset_rsp", 64'({bus.rsp_valid, bus.rsp_res, bus.rsp_flags, bus.rsp_illegal,
                              bus.rsp_cmd}), 64'd0);
        chk("reset_counts", 64'({bus.op_count, bus.illegal_count}), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("ready_after_reset", 64'(bus.req_ready), 64'd1);
        @(posedge clk); #1;

        // ADD 200+100, MUL 3,4, illegal, CMP 5 vs 9 with a long stall
        send(1'b1, 4'd0, 2'b11, 8'd200, 8'd100, 1'b0, 0);
        chk("add_value", 64'(bus.op_count), 64'd1);
        send(1'b1, 4'd9, 2'b11, 8'd3, 8'd4, 1'b0, 1);
        send(1'b1, 4'd0, 2'b01, 8'd7, 8'd8, 1'b0, 0);
        send(1'b1, 4'd8, 2'b11, 8'd5, 8'd9, 1'b0, 5);
        send(1'b0, 4'd13, 2'b11, 8'hF0, 8'h0F, 1'b1, 2);
        send(1'b1, 4'd10, 2'b11, 8'hFF, 8'hFF, 1'b0, 0);
        send(1'b0, 4'd6, 2'b00, 8'h12, 8'h34, 1'b0, 0);
        send(1'b1, 4'd15, 2'b11, 8'h12, 8'h34, 1'b0, 0);

        for (int k = 0; k < 40; k++) begin
            send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)));
        end

        // Reset one cycle into a multiply
        bus.req_valid = 1'b1; bus.req_mode = 1'b1; bus.req_cmd = 4'd9; bus.req_in_val = 2'b11;
        bus.req_opa = 8'd6; bus.req_opb = 8'd7; bus.req_cin = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("mid_exec_ce", 64'(bus.alu_ce), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_ce_drop", 64'({bus.alu_ce, bus.alu_opa, bus.alu_opb, bus.alu_cmd}), 64'd0);
        chk("rst_rsp_drop", 64'({bus.rsp_valid, bus.req_ready}), 64'd0);
        chk("rst_counts", 64'({bus.op_count, bus.illegal_count}), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        exp_ops = 0; exp_ill = 0;
        #1;
        chk("rst_release_ready", 64'(bus.req_ready), 64'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("no_stale_rsp", 64'({bus.rsp_valid, bus.alu_ce}), 64'd0);
        end
        chk("rst_counts_after", 64'({bus.op_count, bus.illegal_count}), 64'd0);
        send(1'b1, 4'd1, 2'b11, 8'd50, 8'd80, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
